// File: rtl/register_arbiter.sv
// -----------------------------------------------------------------------------
// register_arbiter
//
// Purpose
//   Shares a single-port ADDR_W x DATA_W register file (register_unit) between
//   NUM_REQ requesters. One requester is granted at a time. Its request is
//   driven onto the register file pins. The requester then gets read data and
//   a one-cycle completion pulse. This block is the only driver of the register
//   file's load/addr/data_in pins.
//
//   Every access walks IDLE -> ACCESS -> DONE -> IDLE, one cycle per state.
//   The best case is therefore one access every three cycles.
//
// Configuration
//   REG_ARB_FIXED_PRIO_EN  when defined, the lowest asserted request index
//                          always wins and the round-robin pointer stays at 0.
//                          When undefined (the default), arbitration is
//                          round-robin, starting the scan at the requester
//                          after the last winner.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   ADDR_W   register file address width
//   DATA_W   register file data width
//
// Ports
//   clock        in   system clock, rising-edge active
//   reset        in   synchronous active-high reset
//   req          in   per-requester request, held until done
//   we           in   per-requester write enable (1 = write, 0 = read)
//   addr         in   flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata        in   flattened write data, requester i at [i*DATA_W +: DATA_W]
//   gnt          out  one-hot grant, high during ACCESS and DONE
//   done         out  one-hot single-cycle completion pulse (DONE state)
//   rdata        out  shared read data, valid while done is high
//   rf_load      out  register file write strobe (ACCESS, write, not in reset)
//   rf_addr      out  register file address
//   rf_data_in   out  register file write data
//   rf_data_out  in   register file read data, combinational on rf_addr
// -----------------------------------------------------------------------------
module register_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rf_load,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_data_in,
    input  logic [DATA_W-1:0]         rf_data_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t              state_reg;
    logic [PTR_W-1:0]    ptr_reg;         // round-robin scan start
    logic [PTR_W-1:0]    win_reg;         // latched winner index
    logic                we_reg;          // latched write enable of the winner
    logic [NUM_REQ-1:0]  gnt_reg;
    logic [NUM_REQ-1:0]  done_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [ADDR_W-1:0]   rf_addr_reg;     // doubles as the latched address
    logic [DATA_W-1:0]   rf_data_in_reg;  // doubles as the latched write data

    // -------------------------------------------------------------------------
    // Unpack the flattened per-requester buses
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Winner selection
    // rr_idx[k] is the requester visited k-th in the scan, i.e. (ptr + k) mod
    // NUM_REQ. With fixed priority ptr never leaves 0, so the same scan gives
    // lowest-index-wins.
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]    rr_idx [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            assign rr_idx[gi] = PTR_W'((int'(ptr_reg) + gi) % NUM_REQ);
        end
    endgenerate

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;

    // Scan from the far end back toward ptr. The last hit to be assigned is
    // the one closest to ptr, which is the round-robin winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[rr_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = rr_idx[k];
            end
        end
    end

    // Pointer value after the current winner completes (wraps at NUM_REQ).
    logic [PTR_W-1:0]    ptr_after_win;
    assign ptr_after_win = (win_reg == PTR_W'(NUM_REQ - 1)) ? '0
                                                            : win_reg + PTR_W'(1);

    // One-hot decode of the latched winner.
    logic [NUM_REQ-1:0]  win_onehot;
    assign win_onehot = NUM_REQ'(1) << win_reg;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            win_reg        <= '0;
            we_reg         <= 1'b0;
            gnt_reg        <= '0;
            done_reg       <= '0;
            rdata_reg      <= '0;
            rf_addr_reg    <= '0;
            rf_data_in_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    if (win_found) begin
                        // Capture everything now, so later changes on the
                        // request inputs cannot disturb this access.
                        win_reg        <= win_idx;
                        we_reg         <= we[win_idx];
                        rf_addr_reg    <= addr_arr[win_idx];
                        rf_data_in_reg <= wdata_arr[win_idx];
                        gnt_reg        <= NUM_REQ'(1) << win_idx;
                        state_reg      <= ACCESS;
                    end
                end

                ACCESS: begin
                    // The read port is combinational on rf_addr, so the data
                    // is already settled by the end of this cycle.
                    if (!we_reg) begin
                        rdata_reg <= rf_data_out;
                    end
                    done_reg  <= win_onehot;
                    state_reg <= DONE;
                end

                DONE: begin
                    done_reg  <= '0;
                    gnt_reg   <= '0;
`ifdef REG_ARB_FIXED_PRIO_EN
                    ptr_reg   <= '0;
`else
                    ptr_reg   <= ptr_after_win;
`endif
                    state_reg <= IDLE;
                end

                default: begin
                    done_reg  <= '0;
                    gnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // rf_load is gated combinationally by reset. A write caught by reset in
    // the middle of ACCESS therefore never reaches the register file.
    // -------------------------------------------------------------------------
    assign rf_load    = (state_reg == ACCESS) & we_reg & ~reset;
    assign rf_addr    = rf_addr_reg;
    assign rf_data_in = rf_data_in_reg;
    assign gnt        = gnt_reg;
    assign done       = done_reg;
    assign rdata      = rdata_reg;

endmodule
